cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
Round-robin arbiter and broadcast register for the Tomasulo common data bus (CDB). Up to NREQ functional units (ALU, MUL/DIV, load, store-address, ...) each present a result and its reservation-station label through a valid/ready handshake. The arbiter grants one requester per cycle and drives the registered CDB broadcast consumed by the reservation stations, the register status table and the ROB. It replaces fixed-priority selection with a starvation-free policy, a flush path and protocol-error detection.

Parameters:
NREQ, 4, number of requesting functional units (2..8)
DATA_W, 32, result data width
LABEL_W, 5, reservation-station label width; label 0 is reserved as "no producer"
SRC_W, 2, width of source index, must be >= clog2(NREQ)

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous, active-low reset
flush  in  1  synchronous squash (branch mispredict / exception)
req_valid  in  NREQ  per-requester result valid
req_ready  out  NREQ  per-requester grant; transfer = req_valid[i] & req_ready[i]
req_data  in  NREQ*DATA_W  packed results, requester i at bits [i*DATA_W +: DATA_W]
req_label  in  NREQ*LABEL_W  packed labels, requester i at [i*LABEL_W +: LABEL_W]
cdb_valid  out  1  broadcast valid
cdb_data  out  DATA_W  broadcast result
cdb_label  out  LABEL_W  broadcast label
cdb_src  out  SRC_W  index of the broadcasting requester
err  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst_n=0, asynchronous): cdb_valid=0, cdb_data=0, cdb_label=0, cdb_src=0, rr_ptr=0, err=0. req_ready is all zero while rst_n=0.
- Eligible set: req_valid[i] & (req_label[i] != 0).
- Grant (combinational): req_ready is one-hot, or all zero.
  - Search eligible requesters starting at rr_ptr, ascending, wrapping at NREQ-1 -> 0.
  - First eligible index wins.
  - req_ready is all zero when flush=1 or no requester is eligible.
  - req_ready must not depend combinationally on req_data.
- Requester rule: once req_valid is asserted, it stays high with data/label stable until the transfer occurs.
- Broadcast: latency is exactly 1 cycle.
  - A transfer from i in cycle N gives cdb_valid=1, cdb_data=req_data[i], cdb_label=req_label[i], cdb_src=i in cycle N+1.
  - Each broadcast lasts exactly one cycle per transfer.
  - Back-to-back transfers give a continuous cdb_valid.
- Idle bus: when cdb_valid=0, cdb_data, cdb_label and cdb_src are driven 0, so downstream OR-reduced buses stay clean.
- Pointer:
  - After a transfer from i, rr_ptr <= (i+1) mod NREQ. For non-power-of-2 NREQ, the wrap is explicit, not a bit truncation.
  - With no transfer, rr_ptr holds.
- Fairness: a requester holding valid with a nonzero label is granted within NREQ cycles of asserting valid (no flush in between).
- Flush:
  - No grant in the flush cycle.
  - The next cycle has cdb_valid=0 and outputs zeroed, including a broadcast that was due from a transfer in the previous cycle... except that a transfer completed before the flush cycle has already broadcast, so only the register update is squashed.
  - rr_ptr <= 0.
  - err is unaffected.
- Error: err <= 1 (sticky until reset) in any cycle with req_valid[i]=1 and req_label[i]=0. That requester is never granted while its label is 0. Other requesters proceed normally.
- Simultaneous events: flush has priority over grant. Reset has priority over everything.
- Reset mid-operation: any pending grant or broadcast is dropped and outputs go to their reset values immediately.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, then high with req_valid=0 -> all outputs 0, req_ready=0000 for 10 cycles.
- Single request: req_valid=0100, label2=5'd7, data2=32'hDEADBEEF -> req_ready=0100 in that cycle; next cycle cdb_valid=1, cdb_label=7, cdb_data=DEADBEEF, cdb_src=2; rr_ptr=3.
- Full contention: all four requesters valid continuously with labels 1..4 -> grant order 0,1,2,3,0,... and cdb_valid high every cycle after the first; each source broadcasts once per 4 cycles.
- Wrap and skip: rr_ptr=3, req_valid=0011 -> grant 0 then 1; with req_valid=1001 from rr_ptr=1 -> grant 3 then 0.
- Flush: request 1 is granted in cycle N (label 9); flush=1 in N+1 with requester 2 valid -> cdb_valid=1 label 9 in N+1; req_ready=0000 in N+1; cdb_valid=0 in N+2; rr_ptr=0, so requester 2 is granted in N+2.
- Label-0 error: req_valid=0011 with label0=0, label1=6 -> requester 1 granted; err=1 next cycle and stays 1 after req_valid drops; cleared only by rst_n.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the Tomasulo common data bus with a registered,
// one-cycle broadcast stage, synchronous flush and sticky label-0 error flag.
module cdb_arbiter #(
  parameter int NREQ    = 4,
  parameter int DATA_W  = 32,
  parameter int LABEL_W = 5,
  parameter int SRC_W   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*DATA_W-1:0]  req_data,
  input  logic [NREQ*LABEL_W-1:0] req_label,
  output logic                    cdb_valid,
  output logic [DATA_W-1:0]       cdb_data,
  output logic [LABEL_W-1:0]      cdb_label,
  output logic [SRC_W-1:0]        cdb_src,
  output logic                    err
);

  logic [NREQ-1:0]    eligible;
  logic [NREQ-1:0]    badLabel;
  logic               grantFound;
  logic [SRC_W-1:0]   grantIdx;
  logic               foundHi;
  logic               foundLo;
  logic [SRC_W-1:0]   hiIdx;
  logic [SRC_W-1:0]   loIdx;
  logic               transfer;
  logic [DATA_W-1:0]  selData;
  logic [LABEL_W-1:0] selLabel;

  logic               cdb_valid_q, cdb_valid_d;
  logic [DATA_W-1:0]  cdb_data_q,  cdb_data_d;
  logic [LABEL_W-1:0] cdb_label_q, cdb_label_d;
  logic [SRC_W-1:0]   cdb_src_q,   cdb_src_d;
  logic [SRC_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic               err_q,       err_d;

  // Label 0 means "no producer", so such a request is never granted and flags an error.
  always_comb begin
    eligible = '0;
    badLabel = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = req_valid[i] & (req_label[i*LABEL_W +: LABEL_W] != '0);
      badLabel[i] = req_valid[i] & (req_label[i*LABEL_W +: LABEL_W] == '0);
    end
  end

  // Rotating priority: first eligible at or above rr_ptr, otherwise first eligible from 0.
  always_comb begin
    foundHi = 1'b0;
    foundLo = 1'b0;
    hiIdx   = '0;
    loIdx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (eligible[i] && !foundHi && (i >= int'(rr_ptr_q))) begin
        foundHi = 1'b1;
        hiIdx   = SRC_W'(i);
      end
      if (eligible[i] && !foundLo) begin
        foundLo = 1'b1;
        loIdx   = SRC_W'(i);
      end
    end
    grantFound = foundHi | foundLo;
    grantIdx   = foundHi ? hiIdx : loIdx;
  end

  always_comb begin
    req_ready = '0;
    if (grantFound && !flush && rst_n) begin
      req_ready = NREQ'(1) << grantIdx;
    end
  end

  assign transfer = |(req_valid & req_ready);

  always_comb begin
    selData  = '0;
    selLabel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (SRC_W'(i) == grantIdx) begin
        selData  = req_data[i*DATA_W +: DATA_W];
        selLabel = req_label[i*LABEL_W +: LABEL_W];
      end
    end
  end

  // Idle bus cycles drive zeros so OR-reduced downstream buses stay clean.
  always_comb begin
    cdb_valid_d = transfer;
    cdb_data_d  = transfer ? selData  : '0;
    cdb_label_d = transfer ? selLabel : '0;
    cdb_src_d   = transfer ? grantIdx : '0;
    err_d       = err_q | (|badLabel);
    rr_ptr_d    = rr_ptr_q;
    if (flush) begin
      rr_ptr_d = '0;
    end else if (transfer) begin
      rr_ptr_d = (int'(grantIdx) == NREQ-1) ? '0 : grantIdx + SRC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid_q <= 1'b0;
      cdb_data_q  <= '0;
      cdb_label_q <= '0;
      cdb_src_q   <= '0;
      rr_ptr_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_data_q  <= cdb_data_d;
      cdb_label_q <= cdb_label_d;
      cdb_src_q   <= cdb_src_d;
      rr_ptr_q    <= rr_ptr_d;
      err_q       <= err_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_label = cdb_label_q;
  assign cdb_src   = cdb_src_q;
  assign err       = err_q;

endmodule
